nibble_serial_adder: RTL and testbench
======================================

# nibble_serial_adder

Sequential wide adder that sits directly downstream of the existing 4-bit `adder4` stage. It accepts two WIDTH-bit operands plus carry-in, feeds them one nibble per clock through a single `adder4` instance, registers the ripple carry between nibbles, and assembles the WIDTH-bit sum and final carry-out. It trades latency for area and is the wide-add path for datapaths built from the 4-bit adder cell.

## Interface
- `WIDTH`, default 16: operand and sum width; must be a multiple of 4 and at least 4.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled on the rising edge.
- `ina`  in  WIDTH  operand A; captured when `start` is accepted.
- `inb`  in  WIDTH  operand B; captured when `start` is accepted.
- `cin`  in  1  carry-in; captured when `start` is accepted.
- `busy`  out  1  high while nibbles are being processed (RUN).
- `done`  out  1  one-cycle pulse; `sum`/`cout` are valid.
- `sum`  out  WIDTH  result; held until the next accepted start.
- `cout`  out  1  final carry-out; held with `sum`.

## Operation
- N = WIDTH/4 nibbles. Nibble i is bits [4i+3:4i], processed LSB nibble first.
- FSM states:
  - IDLE: `busy`=0, `done`=0.
    - `start`=1 → RUN. Capture `ina`/`inb` into operand registers, carry register ← `cin`, index ← 0.
  - RUN: `busy`=1.
    - Each cycle, nibble[index] of both operands plus the carry register drive `adder4`.
    - The `adder4` sum is written into result nibble[index]. Carry register ← `adder4` cout. index increments.
    - On index = N−1 → DONE. `sum` ← assembled result, `cout` ← last cout.
  - DONE: `done`=1, `busy`=0.
    - `start`=1 → RUN (back-to-back; operands captured as in IDLE).
    - Otherwise → IDLE.
- `start` is ignored while in RUN. In-flight operands are not disturbed.
- `sum`/`cout` change only at the DONE transition. Intermediate nibbles are never visible on `sum`.
- Arithmetic is unsigned modulo 2^WIDTH. `cout` is bit WIDTH of ina+inb+cin.

## Timing
- Reset values: `busy`=0, `done`=0, `sum`=0, `cout`=0. State is IDLE, index 0, carry and operand registers 0.
- `start` sampled at edge k:
  - `busy`=1 after edges k … k+N−1.
  - `done`=1 and the result valid after edge k+N.
  - Latency is N cycles. For WIDTH=16 that is 4 cycles.
- Throughput: with back-to-back starts, one result every N+1 cycles.
- `rst` has priority over everything and takes effect at the next edge, including mid-RUN and in DONE. The partial result is discarded and the outputs return to reset values.
- `rst` and `start` high on the same edge: reset wins and `start` is dropped.
- N=1 (WIDTH=4): RUN lasts one cycle, so the block behaves as a registered `adder4`.

## Structure
- Package `nibble_pkg`:
  - `NIBBLE` = 4.
  - FSM state enum {IDLE, RUN, DONE}.
  - Function computing the index width, $clog2(N) with a minimum of 1.
- One sub-module instance: the existing `adder4` (ports cout, sum, ina, inb, cin), fed by the muxed operand nibbles and the carry register.
- Operand registers, result register, index counter and carry register live in the top level.

## Test plan
- WIDTH=16, start with 0x1234 + 0x4321, cin=0 → `done` 4 cycles after the start edge; `sum`=0x5555, `cout`=0.
- 0x00FF + 0x0001, cin=0 → `sum`=0x0100, `cout`=0 (carry ripples across nibble boundaries).
- 0xFFFF + 0xFFFF, cin=1 → `sum`=0xFFFF, `cout`=1. Then 0xFFFF + 0x0001, cin=0 → `sum`=0x0000, `cout`=1.
- Start 0x1111 + 0x2222, then pulse `start` with 0xAAAA + 0x5555 during RUN → second request ignored; `sum`=0x3333. A start held in the DONE cycle is accepted and its result appears 4 cycles later.
- Assert `rst` on the 2nd RUN cycle → next cycle `busy`=0, `done`=0, `sum`=0, `cout`=0. A new start afterwards completes normally.
- Random operands with a reference model of ina+inb+cin, for WIDTH=4, 16 and 32 → every `done` matches; `done` is exactly one cycle wide.

Source files
------------

// File: rtl/nibble_pkg.sv
// Shared definitions for the nibble-serial wide adder: nibble size,
// FSM state encoding and the index-width helper.
package nibble_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a counter that walks n nibbles; never narrower than one bit.
  function automatic int idx_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/adder4.sv
// Existing 4-bit adder cell: sum and carry-out of two nibbles plus carry-in.
module adder4 (
  output logic       cout,
  output logic [3:0] sum,
  input  logic [3:0] ina,
  input  logic [3:0] inb,
  input  logic       cin
);

  assign {cout, sum} = {1'b0, ina} + {1'b0, inb} + {4'b0000, cin};

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder that pushes one nibble per clock through a single adder4,
// carrying between nibbles in a register and publishing the result at DONE.
module nibble_serial_adder
  import nibble_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int N  = WIDTH / NIBBLE;
  localparam int IW = idx_width(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t state;
  state_t next_state;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic [IW-1:0]    idx;
  logic             carry;
  logic             last;

  logic [3:0] a_nib;
  logic [3:0] b_nib;
  logic [3:0] a4_sum;
  logic       a4_cout;

  assign last  = (idx == LAST);
  assign a_nib = op_a[NIBBLE*idx +: NIBBLE];
  assign b_nib = op_b[NIBBLE*idx +: NIBBLE];

  adder4 u_adder4 (
    .cout (a4_cout),
    .sum  (a4_sum),
    .ina  (a_nib),
    .inb  (b_nib),
    .cin  (carry)
  );

  // The final nibble is merged here so sum can load the complete word directly.
  always_comb begin
    res_next = res;
    res_next[NIBBLE*idx +: NIBBLE] = a4_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (last)  next_state = DONE;
      DONE:    next_state = start ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a  <= '0;
      op_b  <= '0;
      res   <= '0;
      idx   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            op_a  <= ina;
            op_b  <= inb;
            carry <= cin;
            idx   <= '0;
          end
        end
        RUN: begin
          res   <= res_next;
          carry <= a4_cout;
          idx   <= last ? '0 : idx + 1'b1;
          if (last) begin
            sum  <= res_next;
            cout <= a4_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and random checks of nibble_serial_adder at WIDTH 4, 16 and 32
// against hand-computed values and an ina+inb+cin reference.
module tb_nibble_serial_adder;

  logic clk = 1'b0;
  logic rst;

  logic        start4, cin4, busy4, done4, cout4;
  logic [3:0]  ina4, inb4, sum4;
  logic        start16, cin16, busy16, done16, cout16;
  logic [15:0] ina16, inb16, sum16;
  logic        start32, cin32, busy32, done32, cout32;
  logic [31:0] ina32, inb32, sum32;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .ina(ina4), .inb(inb4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  nibble_serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .ina(ina16), .inb(inb16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
  );

  nibble_serial_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .ina(ina32), .inb(inb32), .cin(cin32),
    .busy(busy32), .done(done32), .sum(sum32), .cout(cout32)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic busyOf(input int w);
    return (w == 4) ? busy4 : (w == 16) ? busy16 : busy32;
  endfunction

  function automatic logic doneOf(input int w);
    return (w == 4) ? done4 : (w == 16) ? done16 : done32;
  endfunction

  function automatic logic coutOf(input int w);
    return (w == 4) ? cout4 : (w == 16) ? cout16 : cout32;
  endfunction

  function automatic logic [63:0] sumOf(input int w);
    return (w == 4) ? {60'd0, sum4} : (w == 16) ? {48'd0, sum16} : {32'd0, sum32};
  endfunction

  task automatic driveStart(input int w, input logic s, input logic [63:0] a, input logic [63:0] b, input logic c);
    case (w)
      4:       begin start4  = s; ina4  = a[3:0];  inb4  = b[3:0];  cin4  = c; end
      16:      begin start16 = s; ina16 = a[15:0]; inb16 = b[15:0]; cin16 = c; end
      default: begin start32 = s; ina32 = a[31:0]; inb32 = b[31:0]; cin32 = c; end
    endcase
  endtask

  // Called at a falling edge; the request is sampled on the following rising edge.
  task automatic applyStimulus(input int w, input logic [63:0] a, input logic [63:0] b, input logic c);
    driveStart(w, 1'b1, a, b, c);
    @(negedge clk);
    driveStart(w, 1'b0, a, b, c);
    checkOutput("busy_after_start", {63'd0, busyOf(w)}, 64'd1);
    checkOutput("done_after_start", {63'd0, doneOf(w)}, 64'd0);
  endtask

  // lat0 is the number of rising edges already elapsed since the start edge.
  task automatic waitResult(input int w, input string tag, input logic [63:0] a, input logic [63:0] b,
                            input logic c, input int lat0);
    logic [63:0] m;
    logic [63:0] full;
    int lat;
    m    = (64'd1 << w) - 64'd1;
    full = (a & m) + (b & m) + {63'd0, c};
    lat  = lat0;
    while (!doneOf(w) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, "_done"}, {63'd0, doneOf(w)}, 64'd1);
    checkOutput({tag, "_latency"}, 64'(lat), 64'(w / 4));
    checkOutput({tag, "_sum"}, sumOf(w), full & m);
    checkOutput({tag, "_cout"}, {63'd0, coutOf(w)}, {63'd0, full[w]});
  endtask

  task automatic checkPulse(input int w, input string tag);
    @(negedge clk);
    checkOutput({tag, "_done_width"}, {63'd0, doneOf(w)}, 64'd0);
  endtask

  initial begin
    logic [63:0] ra, rb;
    logic rc;
    int widths[3];
    widths = '{4, 16, 32};

    rst = 1'b1;
    driveStart(4, 1'b0, 64'd0, 64'd0, 1'b0);
    driveStart(16, 1'b0, 64'd0, 64'd0, 1'b0);
    driveStart(32, 1'b0, 64'd0, 64'd0, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", {63'd0, busy16}, 64'd0);
    checkOutput("reset_done", {63'd0, done16}, 64'd0);
    checkOutput("reset_sum", {48'd0, sum16}, 64'd0);
    checkOutput("reset_cout", {63'd0, cout16}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(16, 64'h1234, 64'h4321, 1'b0);
    waitResult(16, "add_5555", 64'h1234, 64'h4321, 1'b0, 0);
    checkOutput("add_5555_hand", {48'd0, sum16}, 64'h5555);
    checkPulse(16, "add_5555");

    applyStimulus(16, 64'h00FF, 64'h0001, 1'b0);
    waitResult(16, "ripple", 64'h00FF, 64'h0001, 1'b0, 0);
    checkOutput("ripple_hand", {48'd0, sum16}, 64'h0100);

    applyStimulus(16, 64'hFFFF, 64'hFFFF, 1'b1);
    waitResult(16, "all_ones", 64'hFFFF, 64'hFFFF, 1'b1, 0);
    checkOutput("all_ones_hand", {47'd0, cout16, sum16}, 64'h1FFFF);

    applyStimulus(16, 64'hFFFF, 64'h0001, 1'b0);
    waitResult(16, "wrap", 64'hFFFF, 64'h0001, 1'b0, 0);
    checkOutput("wrap_hand", {47'd0, cout16, sum16}, 64'h10000);

    // A second request during RUN must be ignored; the first operands finish.
    applyStimulus(16, 64'h1111, 64'h2222, 1'b0);
    driveStart(16, 1'b1, 64'hAAAA, 64'h5555, 1'b1);
    @(negedge clk);
    driveStart(16, 1'b0, 64'hAAAA, 64'h5555, 1'b1);
    waitResult(16, "ignored", 64'h1111, 64'h2222, 1'b0, 1);
    checkOutput("ignored_hand", {48'd0, sum16}, 64'h3333);

    // Start held in the DONE cycle is accepted back to back.
    applyStimulus(16, 64'h0F0F, 64'h0101, 1'b1);
    checkOutput("held_sum_during_run", {48'd0, sum16}, 64'h3333);
    waitResult(16, "b2b", 64'h0F0F, 64'h0101, 1'b1, 0);
    checkOutput("b2b_hand", {48'd0, sum16}, 64'h1011);
    checkPulse(16, "b2b");

    // Reset during the second RUN cycle discards the operation.
    applyStimulus(16, 64'h1234, 64'h1111, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrun_rst_busy", {63'd0, busy16}, 64'd0);
    checkOutput("midrun_rst_done", {63'd0, done16}, 64'd0);
    checkOutput("midrun_rst_sum", {48'd0, sum16}, 64'd0);
    checkOutput("midrun_rst_cout", {63'd0, cout16}, 64'd0);
    applyStimulus(16, 64'h0123, 64'h0456, 1'b1);
    waitResult(16, "after_rst", 64'h0123, 64'h0456, 1'b1, 0);
    checkOutput("after_rst_hand", {48'd0, sum16}, 64'h057A);
    checkPulse(16, "after_rst");

    // Reset and start on the same edge: the start is dropped.
    rst = 1'b1;
    driveStart(16, 1'b1, 64'h0001, 64'h0001, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    driveStart(16, 1'b0, 64'h0001, 64'h0001, 1'b0);
    checkOutput("rst_start_busy", {63'd0, busy16}, 64'd0);
    @(negedge clk);
    checkOutput("rst_start_busy_later", {63'd0, busy16}, 64'd0);
    checkOutput("rst_start_sum", {48'd0, sum16}, 64'd0);

    for (int wi = 0; wi < 3; wi++) begin
      for (int k = 0; k < 6; k++) begin
        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom};
        rc = 1'($urandom_range(0, 1));
        applyStimulus(widths[wi], ra, rb, rc);
        waitResult(widths[wi], $sformatf("rand_w%0d_%0d", widths[wi], k), ra, rb, rc, 0);
        checkPulse(widths[wi], $sformatf("rand_w%0d_%0d", widths[wi], k));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
